// File: rtl/wb_trace_serializer.sv
// Merges the two dual-issue writeback slots into one in-order debug trace stream.
// A small circular FIFO absorbs bursts, and stall back-pressures the writeback stage.
module wb_trace_serializer #(
    parameter int DEPTH     = 8,
    parameter int FILTER_R0 = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_en_0,
    input  logic [4:0]  in_rd_0,
    input  logic [31:0] in_data_0,
    input  logic [31:0] in_pc_0,
    input  logic        in_en_1,
    input  logic [4:0]  in_rd_1,
    input  logic [31:0] in_data_1,
    input  logic [31:0] in_pc_1,
    output logic        stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_wen,
    output logic [4:0]  out_wnum,
    output logic [31:0] out_wdata,
    output logic        overflow,
    output logic [31:0] retire_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_entry;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic          elig_0;
    logic          elig_1;
    logic          pop;
    logic          accept_0;
    logic          accept_1;
    logic          drop;
    logic [AW+1:0] free;
    logic [AW-1:0] addr_1;
    logic [AW:0]   push_n;

    // A same-cycle pop frees its slot for this cycle's pushes; slot 1 is dropped first.
    always_comb begin
        elig_0   = in_en_0 && !((FILTER_R0 != 0) && (in_rd_0 == 5'd0));
        elig_1   = in_en_1 && !((FILTER_R0 != 0) && (in_rd_1 == 5'd0));
        pop      = out_valid && out_ready;
        free     = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
        accept_0 = elig_0 && (free != '0);
        accept_1 = elig_1 && (free > (AW+2)'(accept_0));
        drop     = (elig_0 && !accept_0) || (elig_1 && !accept_1);
        addr_1   = tail + AW'(accept_0);
        push_n   = (AW+1)'(accept_0) + (AW+1)'(accept_1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            retire_cnt <= 32'd0;
        end else begin
            tail  <= tail + AW'(push_n);
            count <= count + push_n - (AW+1)'(pop);
            if (pop) begin
                head       <= head + 1'b1;
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (accept_0) begin
            mem[tail] <= '{pc: in_pc_0, rd: in_rd_0, data: in_data_0};
        end
        if (accept_1) begin
            mem[addr_1] <= '{pc: in_pc_1, rd: in_rd_1, data: in_data_1};
        end
    end

    assign head_entry = mem[head];
    assign out_valid  = (count != '0);
    assign stall      = (count > (AW+1)'(DEPTH - 2));
    assign out_pc     = out_valid ? head_entry.pc   : 32'd0;
    assign out_wnum   = out_valid ? head_entry.rd   : 5'd0;
    assign out_wdata  = out_valid ? head_entry.data : 32'd0;
    assign out_wen    = out_valid ? 4'hf : 4'h0;

endmodule
